input_frontend: RTL and testbench
=================================

# input_frontend

Parametrised board-input front end between raw FPGA pins and the CPU/display logic. It synchronises and debounces NUM_BTN buttons/switches and produces a level plus one-cycle rise/fall pulses for each. It also decodes the rotary encoder with a full quadrature state machine and maintains NUM_PTR independent wrap-around display pointers, with the active pointer chosen by `sel`.

## Interface
- CLK_FREQ, 50: clock frequency in MHz.
- JITTER_US, 10000: debounce window in µs. DEB_CYC = CLK_FREQ*JITTER_US; DEB_CYC ≥ 1.
- NUM_BTN, 4: number of button/switch channels.
- BTN_INIT, {NUM_BTN{1'b0}}: reset level per channel.
- NUM_PTR, 4: number of pointers; power of two, ≥ 2.
- PTR_W, 5: pointer width.
- clk, in, 1: single clock. All logic is on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- btn_i, in, NUM_BTN: raw pins; asynchronous to clk.
- rot_a, rot_b, in, 1: raw encoder pins.
- sel, in, $clog2(NUM_PTR): selects the pointer that rotary steps act on and that `ptr_o` shows.
- ptr_clr, in, 1: synchronous clear of all pointers.
- btn_level, out, NUM_BTN: debounced levels.
- btn_rise, btn_fall, out, NUM_BTN: one-cycle edge pulses.
- rot_inc, rot_dec, out, 1: one-cycle step pulses.
- ptr_o, out, PTR_W: value of pointer[sel].
- ptr_all, out, NUM_PTR*PTR_W: all pointers; pointer k is at bits [k*PTR_W +: PTR_W].

## Operation
- Reset values: btn_level = BTN_INIT; rise, fall, rot_inc and rot_dec = 0; all pointers = 0; rotary FSM = IDLE; debounced a/b = 0; all counters = 0.
- **Debounce, per channel:**
  - Two-flop synchroniser feeds a counter.
  - Counter clears whenever the synchronised value equals the output, and increments while they differ.
  - On the cycle the counter reaches DEB_CYC, the output toggles and the counter clears.
  - Any glitch shorter than DEB_CYC cycles never reaches the output.
  - rot_a and rot_b use identical channels; their debounced levels are not outputs.
- **Edges:** btn_rise and btn_fall are registered and coincide with the cycle the new level first appears. The pulse width is exactly 1 cycle.
- **Rotary FSM** on the debounced pair {a,b}:
  - IDLE: 10 → A_LEAD; 01 → B_LEAD; 11 → WAIT_REL, no step.
  - A_LEAD: 11 → WAIT_REL and emit dec; 00 → IDLE, no step.
  - B_LEAD: 11 → WAIT_REL and emit inc; 00 → IDLE, no step.
  - WAIT_REL: 00 → IDLE. All other codes hold.
  - Result: at most one step per detent; bounce and reversal mid-detent give no step.
- **Pointers:**
  - On an inc/dec transition, pointer[sel] ±= 1, modulo 2^PTR_W. 31+1 = 0 and 0−1 = 31 at PTR_W = 5.
  - `sel` is sampled in the transition cycle.
  - Unselected pointers hold.
  - ptr_clr has priority over a same-cycle step: all pointers go to 0 and the step pulse is still emitted.
- ptr_o is combinational from the pointer registers and `sel`.

## Timing
- Pin change to btn_level: 2 synchroniser cycles + DEB_CYC cycles. Same for the rotary inputs reaching the FSM.
- FSM transition in cycle t → rot_inc/rot_dec high and the updated pointer both visible in cycle t+1.
- rst_n assertion takes effect immediately, mid-debounce or mid-detent. The first step after release requires a fresh IDLE → *_LEAD → 11 sequence.
- `sel` changes take effect on ptr_o in the same cycle.

## Configuration
- INPUT_DEBOUNCE_EN defined: filters operate as above.
- INPUT_DEBOUNCE_EN undefined: counters are removed. The output follows the synchroniser directly, so latency is 2 cycles and edge/FSM behaviour is otherwise identical. This is intended for simulation.

## Structure
- Package input_frontend_pkg holds:
  - the rotary state encoding (IDLE, A_LEAD, B_LEAD, WAIT_REL; 2 bits);
  - a function computing DEB_CYC and the counter width $clog2(DEB_CYC+1).
- Sub-module debounce_ch contains one synchroniser, counter, level register and rise/fall register, with parameters DEB_CYC and INIT. It is instantiated NUM_BTN+2 times.
- The top level holds the rotary FSM, the pointer array and the output muxing.

## Test plan
All scenarios use CLK_FREQ=1, JITTER_US=4 (DEB_CYC=4), PTR_W=5, NUM_PTR=4.
- Reset: rst_n=0 with BTN_INIT=4'b0010 → btn_level=0010, pointers 0, pulses 0. Release with inputs steady → no pulses.
- btn_i[0] pulsed high for 3 cycles → no change. btn_i[0] held high → btn_level[0]=1 exactly 6 cycles after the pin change, with btn_rise[0] high for 1 cycle in that same cycle. Release → btn_fall[0] 6 cycles later.
- sel=2; ab sequence 00,10,11,01,00, each held 10 cycles → one rot_dec; pointer2 goes 0→31; others stay 0; ptr_o=31.
- sel=1; ab 00,01,11,00 → one rot_inc, pointer1=1. Then ab 00,10,00 (reversal) → no pulse. Then 00 → 11 direct → no pulse.
- Step and ptr_clr coinciding in the same cycle → all pointers 0 next cycle; pulse still emitted.
- rst_n asserted while the FSM is in A_LEAD and a debounce count is mid-way → immediate reset values. After release, ab=11 gives no step until passing through IDLE.

Source files
------------

// File: rtl/input_frontend_pkg.sv
// -----------------------------------------------------------------------------
// input_frontend_pkg
// Shared definitions for the board-input front end:
//   - rot_state_t  : rotary quadrature FSM state encoding (2 bits)
//   - deb_cycles() : debounce window in clock cycles (MHz * us)
//   - deb_cnt_w()  : width of a counter that must be able to hold DEB_CYC
// -----------------------------------------------------------------------------
package input_frontend_pkg;

    typedef enum logic [1:0] {
        ROT_IDLE     = 2'd0,
        ROT_A_LEAD   = 2'd1,
        ROT_B_LEAD   = 2'd2,
        ROT_WAIT_REL = 2'd3
    } rot_state_t;

    function automatic int deb_cycles(input int clk_freq_mhz, input int jitter_us);
        return clk_freq_mhz * jitter_us;
    endfunction

    function automatic int deb_cnt_w(input int deb_cyc);
        return (deb_cyc < 1) ? 1 : $clog2(deb_cyc + 1);
    endfunction

endpackage

// File: rtl/input_frontend_debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One input channel: two-flop synchroniser, debounce counter, level register
// and registered one-cycle rise/fall pulses that coincide with the new level.
//
// Build option: INPUT_DEBOUNCE_EN
//   defined   -> level toggles once the synchronised input has differed from it
//                for DEB_CYC consecutive cycles (glitches shorter are dropped)
//   undefined -> no counter; the level is the second synchroniser flop
//
// Ports
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   i_raw    : raw pin, asynchronous to clk
//   o_level  : debounced level (resets to INIT)
//   o_rise   : one-cycle pulse in the first cycle o_level reads 1
//   o_fall   : one-cycle pulse in the first cycle o_level reads 0
// -----------------------------------------------------------------------------
module debounce_ch
    import input_frontend_pkg::*;
#(
    parameter int   DEB_CYC = 1,
    parameter logic INIT    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    if (DEB_CYC < 1) begin : g_deb_chk
        $error("debounce_ch: DEB_CYC must be at least 1");
    end

    logic r_sync1;
    logic r_level;
    logic r_rise;
    logic r_fall;

`ifdef INPUT_DEBOUNCE_EN
    localparam int                CNT_W    = deb_cnt_w(DEB_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             w_flip;

    // The counter value DEB_CYC is never stored: the cycle that would reach it
    // is the cycle the level flips and the counter clears.
    assign w_flip = (r_sync2 != r_level) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= INIT;
            r_sync2 <= INIT;
            r_level <= INIT;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= w_flip & ~r_level;
            r_fall  <= w_flip &  r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    // Second synchroniser flop doubles as the level register, giving a
    // two-cycle pin-to-level latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= INIT;
            r_level <= INIT;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_level <= r_sync1;
            r_rise  <=  r_sync1 & ~r_level;
            r_fall  <= ~r_sync1 &  r_level;
        end
    end
`endif

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/input_frontend.sv
// -----------------------------------------------------------------------------
// input_frontend
// Board-input front end: debounced buttons with edge pulses, a quadrature
// rotary decoder and NUM_PTR wrap-around pointers steered by the encoder.
//
// Build option: INPUT_DEBOUNCE_EN (see debounce_ch); undefined removes the
// debounce counters and leaves only the synchronisers.
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   btn_i[NUM_BTN]     : raw button/switch pins
//   rot_a, rot_b       : raw encoder pins
//   sel                : pointer that rotary steps act on and ptr_o shows
//   ptr_clr            : synchronous clear of all pointers (wins over a step)
//   btn_level/rise/fall: debounced levels and one-cycle edge pulses
//   rot_inc, rot_dec   : one-cycle step pulses
//   ptr_o              : pointer[sel], combinational
//   ptr_all            : pointer k at [k*PTR_W +: PTR_W]
//
// Rotary FSM, input is the debounced pair {a,b}
//   state        | meaning
//   ROT_IDLE     | detent, both released (00)
//   ROT_A_LEAD   | a went high first (10); 11 next is a dec step
//   ROT_B_LEAD   | b went high first (01); 11 next is an inc step
//   ROT_WAIT_REL | step taken or ambiguous 11; wait for 00
// -----------------------------------------------------------------------------
module input_frontend
    import input_frontend_pkg::*;
#(
    parameter int                 CLK_FREQ  = 50,
    parameter int                 JITTER_US = 10000,
    parameter int                 NUM_BTN   = 4,
    parameter logic [NUM_BTN-1:0] BTN_INIT  = '0,
    parameter int                 NUM_PTR   = 4,
    parameter int                 PTR_W     = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_BTN-1:0]         btn_i,
    input  logic                       rot_a,
    input  logic                       rot_b,
    input  logic [$clog2(NUM_PTR)-1:0] sel,
    input  logic                       ptr_clr,
    output logic [NUM_BTN-1:0]         btn_level,
    output logic [NUM_BTN-1:0]         btn_rise,
    output logic [NUM_BTN-1:0]         btn_fall,
    output logic                       rot_inc,
    output logic                       rot_dec,
    output logic [PTR_W-1:0]           ptr_o,
    output logic [NUM_PTR*PTR_W-1:0]   ptr_all
);

    localparam int DEB_CYC = deb_cycles(CLK_FREQ, JITTER_US);

    if (NUM_PTR < 2 || (NUM_PTR & (NUM_PTR - 1)) != 0) begin : g_ptr_chk
        $error("input_frontend: NUM_PTR must be a power of two >= 2");
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_ch #(
            .DEB_CYC (DEB_CYC),
            .INIT    (BTN_INIT[g])
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (btn_i[g]),
            .o_level (btn_level[g]),
            .o_rise  (btn_rise[g]),
            .o_fall  (btn_fall[g])
        );
    end

    logic w_a_lvl, w_a_rise, w_a_fall;
    logic w_b_lvl, w_b_rise, w_b_fall;

    debounce_ch #(.DEB_CYC(DEB_CYC), .INIT(1'b0)) u_deb_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (rot_a),
        .o_level (w_a_lvl),
        .o_rise  (w_a_rise),
        .o_fall  (w_a_fall)
    );

    debounce_ch #(.DEB_CYC(DEB_CYC), .INIT(1'b0)) u_deb_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (rot_b),
        .o_level (w_b_lvl),
        .o_rise  (w_b_rise),
        .o_fall  (w_b_fall)
    );

    logic [1:0] w_ab;
    logic       w_ab_evt;

    assign w_ab = {w_a_lvl, w_b_lvl};
    // Every state is self-stable for the code that led into it, so the FSM
    // only needs to evaluate in the cycle a debounced level has just changed.
    assign w_ab_evt = w_a_rise | w_a_fall | w_b_rise | w_b_fall;

    rot_state_t r_state;
    rot_state_t w_state_nxt;
    logic       w_inc;
    logic       w_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ROT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        if (w_ab_evt) begin
            case (r_state)
                ROT_IDLE: begin
                    case (w_ab)
                        2'b10:   w_state_nxt = ROT_A_LEAD;
                        2'b01:   w_state_nxt = ROT_B_LEAD;
                        2'b11:   w_state_nxt = ROT_WAIT_REL;
                        default: w_state_nxt = ROT_IDLE;
                    endcase
                end
                ROT_A_LEAD: begin
                    if (w_ab == 2'b11) begin
                        w_state_nxt = ROT_WAIT_REL;
                        w_dec       = 1'b1;
                    end else if (w_ab == 2'b00) begin
                        w_state_nxt = ROT_IDLE;
                    end
                end
                ROT_B_LEAD: begin
                    if (w_ab == 2'b11) begin
                        w_state_nxt = ROT_WAIT_REL;
                        w_inc       = 1'b1;
                    end else if (w_ab == 2'b00) begin
                        w_state_nxt = ROT_IDLE;
                    end
                end
                ROT_WAIT_REL: begin
                    if (w_ab == 2'b00) begin
                        w_state_nxt = ROT_IDLE;
                    end
                end
                default: w_state_nxt = ROT_IDLE;
            endcase
        end
    end

    logic             r_inc;
    logic             r_dec;
    logic [PTR_W-1:0] r_ptr [NUM_PTR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inc <= 1'b0;
            r_dec <= 1'b0;
            for (int k = 0; k < NUM_PTR; k++) begin
                r_ptr[k] <= '0;
            end
        end else begin
            r_inc <= w_inc;
            r_dec <= w_dec;
            if (ptr_clr) begin
                for (int k = 0; k < NUM_PTR; k++) begin
                    r_ptr[k] <= '0;
                end
            end else if (w_inc) begin
                r_ptr[sel] <= r_ptr[sel] + 1'b1;
            end else if (w_dec) begin
                r_ptr[sel] <= r_ptr[sel] - 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_PTR; k++) begin : g_ptr_out
        assign ptr_all[k*PTR_W +: PTR_W] = r_ptr[k];
    end

    assign ptr_o   = r_ptr[sel];
    assign rot_inc = r_inc;
    assign rot_dec = r_dec;

endmodule

// File: tb/tb_input_frontend.sv
module tb_input_frontend;

    localparam int NUM_BTN = 4;
    localparam int NUM_PTR = 4;
    localparam int PTR_W   = 5;
`ifdef INPUT_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic                     clk;
    logic                     rst_n;
    logic [NUM_BTN-1:0]       btn_i;
    logic                     rot_a;
    logic                     rot_b;
    logic [1:0]               sel;
    logic                     ptr_clr;
    logic [NUM_BTN-1:0]       btn_level;
    logic [NUM_BTN-1:0]       btn_rise;
    logic [NUM_BTN-1:0]       btn_fall;
    logic                     rot_inc;
    logic                     rot_dec;
    logic [PTR_W-1:0]         ptr_o;
    logic [NUM_PTR*PTR_W-1:0] ptr_all;

    int n_checks = 0;
    int n_errors = 0;

    int inc_cnt  = 0;
    int dec_cnt  = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    input_frontend #(
        .CLK_FREQ  (1),
        .JITTER_US (4),
        .NUM_BTN   (NUM_BTN),
        .BTN_INIT  (4'b0010),
        .NUM_PTR   (NUM_PTR),
        .PTR_W     (PTR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn_i),
        .rot_a     (rot_a),
        .rot_b     (rot_b),
        .sel       (sel),
        .ptr_clr   (ptr_clr),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .rot_inc   (rot_inc),
        .rot_dec   (rot_dec),
        .ptr_o     (ptr_o),
        .ptr_all   (ptr_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse-high cycle counters, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (rot_inc)   inc_cnt  = inc_cnt + 1;
        if (rot_dec)   dec_cnt  = dec_cnt + 1;
        if (|btn_rise) rise_cnt = rise_cnt + 1;
        if (|btn_fall) fall_cnt = fall_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input logic a, input logic b, input int n);
        rot_a = a;
        rot_b = b;
        tick(n);
    endtask

    task automatic test_reset;
        int r0, f0;
        rst_n = 1'b0; btn_i = 4'b0010; rot_a = 1'b0; rot_b = 1'b0;
        sel = 2'd0; ptr_clr = 1'b0;
        tick(3);
        n_checks++;
        if (btn_level !== 4'b0010) begin
            $display("FAIL reset_level: got %b expected 0010", btn_level); n_errors++;
        end
        n_checks++;
        if (ptr_all !== '0 || ptr_o !== '0) begin
            $display("FAIL reset_ptr: got %h/%h expected 0/0", ptr_all, ptr_o); n_errors++;
        end
        n_checks++;
        if ({btn_rise, btn_fall, rot_inc, rot_dec} !== '0) begin
            $display("FAIL reset_pulses: got %b expected 0", {btn_rise, btn_fall, rot_inc, rot_dec}); n_errors++;
        end
        r0 = rise_cnt; f0 = fall_cnt;
        rst_n = 1'b1;
        tick(10);
        n_checks++;
        if (rise_cnt != r0 || fall_cnt != f0) begin
            $display("FAIL release_pulses: got rise %0d fall %0d expected 0 0", rise_cnt - r0, fall_cnt - f0); n_errors++;
        end
        n_checks++;
        if (btn_level !== 4'b0010) begin
            $display("FAIL release_level: got %b expected 0010", btn_level); n_errors++;
        end
    endtask

    task automatic test_glitch;
        int r0, f0;
        r0 = rise_cnt; f0 = fall_cnt;
        btn_i[0] = 1'b1;
        tick(3);
        btn_i[0] = 1'b0;
        tick(12);
`ifdef INPUT_DEBOUNCE_EN
        n_checks++;
        if (rise_cnt != r0 || fall_cnt != f0) begin
            $display("FAIL glitch_pulses: got rise %0d fall %0d expected 0 0", rise_cnt - r0, fall_cnt - f0); n_errors++;
        end
`else
        n_checks++;
        if (rise_cnt - r0 != 1 || fall_cnt - f0 != 1) begin
            $display("FAIL glitch_pulses: got rise %0d fall %0d expected 1 1", rise_cnt - r0, fall_cnt - f0); n_errors++;
        end
`endif
        n_checks++;
        if (btn_level !== 4'b0010) begin
            $display("FAIL glitch_level: got %b expected 0010", btn_level); n_errors++;
        end
    endtask

    task automatic test_button;
        logic exp_lvl, exp_pulse;
        btn_i[0] = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick(1);
            exp_lvl   = (k >= LAT);
            exp_pulse = (k == LAT);
            n_checks++;
            if (btn_level[0] !== exp_lvl) begin
                $display("FAIL rise_level c%0d: got %b expected %b", k, btn_level[0], exp_lvl); n_errors++;
            end
            n_checks++;
            if (btn_rise[0] !== exp_pulse || btn_fall[0] !== 1'b0) begin
                $display("FAIL rise_pulse c%0d: got r%b f%b expected r%b f0", k, btn_rise[0], btn_fall[0], exp_pulse); n_errors++;
            end
        end
        btn_i[0] = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick(1);
            exp_lvl   = (k < LAT);
            exp_pulse = (k == LAT);
            n_checks++;
            if (btn_level[0] !== exp_lvl) begin
                $display("FAIL fall_level c%0d: got %b expected %b", k, btn_level[0], exp_lvl); n_errors++;
            end
            n_checks++;
            if (btn_fall[0] !== exp_pulse || btn_rise[0] !== 1'b0) begin
                $display("FAIL fall_pulse c%0d: got f%b r%b expected f%b r0", k, btn_fall[0], btn_rise[0], exp_pulse); n_errors++;
            end
        end
        n_checks++;
        if (btn_level[3:1] !== 3'b001) begin
            $display("FAIL other_levels: got %b expected 001", btn_level[3:1]); n_errors++;
        end
    endtask

    task automatic test_rot_dec;
        int i0, d0;
        sel = 2'd2;
        i0 = inc_cnt; d0 = dec_cnt;
        set_ab(0, 0, 10); set_ab(1, 0, 10); set_ab(1, 1, 10); set_ab(0, 1, 10); set_ab(0, 0, 10);
        n_checks++;
        if (dec_cnt - d0 != 1 || inc_cnt != i0) begin
            $display("FAIL dec_count: got dec %0d inc %0d expected 1 0", dec_cnt - d0, inc_cnt - i0); n_errors++;
        end
        n_checks++;
        if (ptr_all !== {5'd0, 5'd31, 5'd0, 5'd0}) begin
            $display("FAIL dec_ptr_all: got %h expected %h", ptr_all, {5'd0, 5'd31, 5'd0, 5'd0}); n_errors++;
        end
        n_checks++;
        if (ptr_o !== 5'd31) begin
            $display("FAIL dec_ptr_o: got %0d expected 31", ptr_o); n_errors++;
        end
    endtask

    task automatic test_rot_inc;
        int i0, d0;
        sel = 2'd1;
        i0 = inc_cnt; d0 = dec_cnt;
        set_ab(0, 0, 10); set_ab(0, 1, 10); set_ab(1, 1, 10); set_ab(0, 0, 10);
        n_checks++;
        if (inc_cnt - i0 != 1 || dec_cnt != d0) begin
            $display("FAIL inc_count: got inc %0d dec %0d expected 1 0", inc_cnt - i0, dec_cnt - d0); n_errors++;
        end
        n_checks++;
        if (ptr_o !== 5'd1) begin
            $display("FAIL inc_ptr_o: got %0d expected 1", ptr_o); n_errors++;
        end
        i0 = inc_cnt; d0 = dec_cnt;
        set_ab(0, 0, 10); set_ab(1, 0, 10); set_ab(0, 0, 10);
        n_checks++;
        if (inc_cnt != i0 || dec_cnt != d0) begin
            $display("FAIL reversal: got inc %0d dec %0d expected 0 0", inc_cnt - i0, dec_cnt - d0); n_errors++;
        end
        set_ab(1, 1, 10); set_ab(0, 0, 10);
        n_checks++;
        if (inc_cnt != i0 || dec_cnt != d0) begin
            $display("FAIL direct_11: got inc %0d dec %0d expected 0 0", inc_cnt - i0, dec_cnt - d0); n_errors++;
        end
        n_checks++;
        if (ptr_all !== {5'd0, 5'd31, 5'd1, 5'd0}) begin
            $display("FAIL inc_ptr_all: got %h expected %h", ptr_all, {5'd0, 5'd31, 5'd1, 5'd0}); n_errors++;
        end
        sel = 2'd2;
        #1;
        n_checks++;
        if (ptr_o !== 5'd31) begin
            $display("FAIL sel_mux2: got %0d expected 31", ptr_o); n_errors++;
        end
        sel = 2'd1;
        #1;
        n_checks++;
        if (ptr_o !== 5'd1) begin
            $display("FAIL sel_mux1: got %0d expected 1", ptr_o); n_errors++;
        end
    endtask

    task automatic test_step_clr;
        int i0;
        sel = 2'd1;
        set_ab(0, 1, 10);
        i0 = inc_cnt;
        set_ab(1, 1, LAT);
        n_checks++;
        if (inc_cnt != i0 || ptr_o !== 5'd1) begin
            $display("FAIL clr_pre: got inc %0d ptr %0d expected 0 1", inc_cnt - i0, ptr_o); n_errors++;
        end
        ptr_clr = 1'b1;
        tick(1);
        ptr_clr = 1'b0;
        n_checks++;
        if (rot_inc !== 1'b1) begin
            $display("FAIL clr_pulse: got %b expected 1", rot_inc); n_errors++;
        end
        n_checks++;
        if (ptr_all !== '0) begin
            $display("FAIL clr_ptr_all: got %h expected 0", ptr_all); n_errors++;
        end
        tick(1);
        n_checks++;
        if (rot_inc !== 1'b0 || inc_cnt - i0 != 1) begin
            $display("FAIL clr_pulse_width: got inc %b count %0d expected 0 1", rot_inc, inc_cnt - i0); n_errors++;
        end
        set_ab(0, 0, 10);
    endtask

    task automatic test_reset_mid;
        int i0, d0, r0;
        sel = 2'd0;
        set_ab(1, 0, 10); set_ab(1, 1, 10); set_ab(0, 0, 10);
        n_checks++;
        if (ptr_o !== 5'd31) begin
            $display("FAIL premid_ptr: got %0d expected 31", ptr_o); n_errors++;
        end
        set_ab(1, 0, 10);
        btn_i[3] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (btn_level !== 4'b0010 || ptr_all !== '0) begin
            $display("FAIL midrst_state: got lvl %b ptr %h expected 0010 0", btn_level, ptr_all); n_errors++;
        end
        n_checks++;
        if ({btn_rise, btn_fall, rot_inc, rot_dec} !== '0) begin
            $display("FAIL midrst_pulses: got %b expected 0", {btn_rise, btn_fall, rot_inc, rot_dec}); n_errors++;
        end
        btn_i = 4'b0010;
        rot_a = 1'b1; rot_b = 1'b1;
        tick(2);
        rst_n = 1'b1;
        i0 = inc_cnt; d0 = dec_cnt; r0 = rise_cnt;
        tick(15);
        n_checks++;
        if (inc_cnt != i0 || dec_cnt != d0 || rise_cnt != r0) begin
            $display("FAIL post_rst_11: got inc %0d dec %0d rise %0d expected 0 0 0", inc_cnt - i0, dec_cnt - d0, rise_cnt - r0); n_errors++;
        end
        n_checks++;
        if (ptr_all !== '0 || btn_level !== 4'b0010) begin
            $display("FAIL post_rst_state: got ptr %h lvl %b expected 0 0010", ptr_all, btn_level); n_errors++;
        end
        set_ab(0, 0, 10); set_ab(1, 0, 10); set_ab(1, 1, 10); set_ab(0, 0, 10);
        n_checks++;
        if (dec_cnt - d0 != 1 || inc_cnt != i0 || ptr_o !== 5'd31) begin
            $display("FAIL post_rst_step: got dec %0d inc %0d ptr %0d expected 1 0 31", dec_cnt - d0, inc_cnt - i0, ptr_o); n_errors++;
        end
    endtask

    initial begin
        test_reset;
        test_glitch;
        test_button;
        test_rot_dec;
        test_rot_inc;
        test_step_clr;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
